// File: rtl/sm83_instr_assembler.sv
// sm83_instr_assembler: assembles SM83 opcode/operand bytes into whole
// instructions (CB prefix, 0-2 immediates, start PC) and queues them.
// Ports: clk, rst (async, active-high), flush/flush_pc, byte input
// handshake (in_valid/in_ready/in_byte), instruction output handshake
// (out_valid/out_ready plus out_opcode, out_is_cb, out_imm, out_len,
// out_pc, out_illegal) and count of queued entries.
module sm83_instr_assembler #(
  parameter int DEPTH = 4,
  parameter int PC_W = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [PC_W-1:0]            flush_pc,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [7:0]                 in_byte,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [7:0]                 out_opcode,
  output logic                       out_is_cb,
  output logic [15:0]                out_imm,
  output logic [1:0]                 out_len,
  output logic [PC_W-1:0]            out_pc,
  output logic                       out_illegal,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [7:0]      op;
    logic            cb;
    logic [15:0]     imm;
    logic [1:0]      len;
    logic [PC_W-1:0] pc;
    logic            ill;
  } ent_t;

  typedef enum logic [1:0] {
    S_OP,
    S_CB,
    S_IMM_LO,
    S_IMM_HI
  } state_t;

  function automatic logic [1:0] imm_cnt(input logic [7:0] op);
    logic [1:0] n;
    n = 2'd0;
    case (op)
      8'h06, 8'h0E, 8'h16, 8'h1E,
      8'h26, 8'h2E, 8'h36, 8'h3E,
      8'h10, 8'h18, 8'h20, 8'h28,
      8'h30, 8'h38, 8'hC6, 8'hCE,
      8'hD6, 8'hDE, 8'hE6, 8'hEE,
      8'hF6, 8'hFE, 8'hE0, 8'hF0,
      8'hE8, 8'hF8: n = 2'd1;
      8'h01, 8'h11, 8'h21, 8'h31,
      8'h08, 8'hC2, 8'hC3, 8'hC4,
      8'hCA, 8'hCC, 8'hCD, 8'hD2,
      8'hD4, 8'hDA, 8'hDC, 8'hEA,
      8'hFA: n = 2'd2;
      default: n = 2'd0;
    endcase
    return n;
  endfunction

  function automatic logic is_ill(input logic [7:0] op);
    logic r;
    r = 1'b0;
    case (op)
      8'hD3, 8'hDB, 8'hDD, 8'hE3,
      8'hE4, 8'hEB, 8'hEC, 8'hED,
      8'hF4, 8'hFC, 8'hFD: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pcs_q, pcs_d;
  logic [7:0]      op_q, op_d;
  logic [7:0]      lo_q, lo_d;
  ent_t            mem_q [DEPTH];
  ent_t            mem_d [DEPTH];
  logic [AW-1:0]   wr_q, wr_d;
  logic [AW-1:0]   rd_q, rd_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic accept;
  logic pop;
  logic push;
  ent_t ent;
  ent_t head;

  assign in_ready = !rst && !flush && (cnt_q != CW'(DEPTH));
  assign accept = in_valid && in_ready;
  assign out_valid = (cnt_q != '0);
  // A pop coinciding with flush is swallowed by the pointer reset.
  assign pop = out_valid && out_ready && !flush;
  assign count = cnt_q;

  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    pcs_d = pcs_q;
    op_d = op_q;
    lo_d = lo_q;
    push = 1'b0;
    ent = '0;
    if (flush) begin
      state_d = S_OP;
      pc_d = flush_pc;
    end else if (accept) begin
      pc_d = pc_q + PC_W'(1);
      unique case (state_q)
        S_OP: begin
          pcs_d = pc_q;
          op_d = in_byte;
          if (in_byte == 8'hCB) begin
            state_d = S_CB;
          end else if (imm_cnt(in_byte) == 2'd0) begin
            push = 1'b1;
            ent = '{op: in_byte, cb: 1'b0, imm: 16'h0,
                    len: 2'd1, pc: pc_q,
                    ill: is_ill(in_byte)};
          end else begin
            state_d = S_IMM_LO;
          end
        end
        S_CB: begin
          push = 1'b1;
          ent = '{op: in_byte, cb: 1'b1, imm: 16'h0,
                  len: 2'd2, pc: pcs_q, ill: 1'b0};
          state_d = S_OP;
        end
        S_IMM_LO: begin
          lo_d = in_byte;
          if (imm_cnt(op_q) == 2'd1) begin
            push = 1'b1;
            ent = '{op: op_q, cb: 1'b0,
                    imm: {8'h00, in_byte},
                    len: 2'd2, pc: pcs_q, ill: 1'b0};
            state_d = S_OP;
          end else begin
            state_d = S_IMM_HI;
          end
        end
        S_IMM_HI: begin
          push = 1'b1;
          ent = '{op: op_q, cb: 1'b0,
                  imm: {in_byte, lo_q},
                  len: 2'd3, pc: pcs_q, ill: 1'b0};
          state_d = S_OP;
        end
        default: state_d = S_OP;
      endcase
    end
  end

  always_comb begin
    mem_d = mem_q;
    wr_d = wr_q;
    rd_d = rd_q;
    cnt_d = cnt_q;
    if (flush) begin
      wr_d = '0;
      rd_d = '0;
      cnt_d = '0;
    end else begin
      if (push) begin
        mem_d[wr_q] = ent;
        wr_d = wr_q + AW'(1);
      end
      if (pop) begin
        rd_d = rd_q + AW'(1);
      end
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_OP;
      pc_q <= RESET_PC;
      pcs_q <= RESET_PC;
      op_q <= '0;
      lo_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      pcs_q <= pcs_d;
      op_q <= op_d;
      lo_q <= lo_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
      mem_q <= mem_d;
    end
  end

  // Data fields read zero whenever the queue is empty.
  assign head = out_valid ? mem_q[rd_q] : '0;
  assign out_opcode = head.op;
  assign out_is_cb = head.cb;
  assign out_imm = head.imm;
  assign out_len = head.len;
  assign out_pc = head.pc;
  assign out_illegal = head.ill;

endmodule

// File: doc/sm83_instr_assembler.md
# sm83_instr_assembler

Byte-stream instruction assembler sitting between fetch and the per-instruction decoder. It accepts opcode and operand bytes one per handshake. It tracks the CB prefix and collects 0–2 immediate bytes per opcode, tags each instruction with the PC of its first byte, and queues complete instructions in a DEPTH-entry FIFO. Decode then sees whole instructions instead of raw bytes. The block generalises single-byte decode with prefix state, operand gathering, PC tracking, flush and buffering.

## Interface
- DEPTH, 4: FIFO entries; power of 2, ≥2.
- PC_W, 16: PC width.
- RESET_PC, 0: PC of first byte after reset.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- flush  in  1  discard partial instruction and all queued entries.
- flush_pc  in  PC_W  PC of next accepted byte after flush.
- in_valid  in  1  in_byte valid.
- in_ready  out  1  byte accepted when in_valid && in_ready.
- in_byte  in  8  opcode/operand byte.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer takes head.
- out_opcode  out  8  opcode; for CB instructions, the byte after CB.
- out_is_cb  out  1  CB-prefixed instruction.
- out_imm  out  16  immediate; little-endian for 2 bytes; 1 byte in [7:0] with [15:8]=0, no sign extension; 0 if none.
- out_len  out  2  total bytes, 1..3; CB = 2.
- out_pc  out  PC_W  PC of first byte.
- out_illegal  out  1  opcode is D3, DB, DD, E3, E4, EB, EC, ED, F4, FC or FD.
- count  out  $clog2(DEPTH+1)  queued entries.

## Operation
- Immediate count per opcode:
  - 1 byte: 06 0E 16 1E 26 2E 36 3E, 10 (STOP), 18 20 28 30 38, C6 CE D6 DE E6 EE F6 FE, E0 F0 E8 F8.
  - 2 bytes: 01 11 21 31 08, C2 C3 C4 CA CC CD D2 D4 DA DC, EA FA.
  - All others 0, including illegal opcodes and CB-table bytes.
- FSM states:
  - S_OP:
    - CB → S_CB.
    - 0 immediates → push, stay.
    - 1 immediate → S_IMM_LO, hi=0.
    - 2 immediates → S_IMM_LO, hi expected.
  - S_CB: any byte → push (is_cb=1, len 2, imm 0) → S_OP.
  - S_IMM_LO: capture imm[7:0]. If 1 immediate → push → S_OP; else → S_IMM_HI.
  - S_IMM_HI: capture imm[15:8] → push → S_OP.
- Opcode, pc_start and imm_lo are held in registers until push.
- pc_q increments by 1 per accepted byte, modulo 2^PC_W. pc_start latches pc_q on each byte accepted in S_OP.
- in_ready = !rst && !flush && count != DEPTH. A full FIFO stalls all bytes, including mid-instruction operands.
- Pop when out_valid && out_ready.
  - Push and pop in the same cycle: count unchanged.
  - Pushing while full is impossible (in_ready low).
- flush, at the edge:
  - FSM → S_OP; FIFO pointers and count → 0; pc_q ← flush_pc.
  - A pop in the same cycle is absorbed, with no other effect.
  - Partial instructions are discarded silently.
- Reset: FSM S_OP, pc_q=RESET_PC, count=0, out_valid=0. All out_* data fields read 0 while empty.

## Timing
- Latency: the final byte accepted at edge N gives out_valid=1 from edge N (same clock as the push) when the FIFO was empty. There is no combinational in→out path.
- out_* are driven from the FIFO head register/RAM read. They are stable while out_valid && !out_ready.
- in_ready depends only on count, flush and rst. There is no path from in_valid or out_ready.
- Throughput: 1 byte/cycle; a 3-byte instruction pushes once every 3 cycles.
- flush asserted at edge N: out_valid=0 and count=0 after N. in_ready=1 again in the cycle after flush deasserts.
- Asynchronous reset asserted mid-instruction: state is cleared immediately, and the partial instruction is lost.

## Test plan
- After reset, feed 01 34 12 00 → entry1 {op 01, len 3, imm 1234, pc 0000}, entry2 {op 00, len 1, pc 0003}; count peaks at 2 with out_ready=0.
- Feed CB 7C, then E0 FF → {op 7C, is_cb 1, len 2, imm 0000, pc 0000}, then {op E0, len 2, imm 00FF, pc 0002}.
- DEPTH=4, out_ready=0, feed 5× 00 → in_ready drops after the 4th byte and count=4. The 5th byte is held. Set out_ready=1 for one cycle → the 5th byte is accepted the next cycle, with pc 0004.
- Feed C3 34, then flush with flush_pc=0150, then 00 → exactly one entry {op 00, pc 0150}; the C3 is never emitted. Flush with 2 queued entries → count=0 and out_valid=0 the next cycle.
- Feed D3 → {op D3, illegal 1, len 1}. Feed 10 00 → {op 10, len 2, imm 0000}.
- flush_pc=FFFF, feed 3E 12 00 → {op 3E, imm 0012, pc FFFF}, then {op 00, pc 0001}.
- Pulse rst after CB is accepted, then feed 00 → a plain {op 00, is_cb 0, pc RESET_PC}.
